run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
- Upstream control stage for the 9-bit processor core.
- Preloads a block of bytes into data memory through the core's memory-side port, then holds the core's start/Init high for a fixed number of cycles and releases it.
- Counts executed cycles until the core's haltProgram rises, then streams a result window of data memory out over a valid/ready port.
- Sits between the bench/host and the core top level; it drives that level's start input and consumes its haltProgram output.

Parameters:
- ADDR_W, 8, data-memory address width.
- LOAD_BASE, 0, first data-memory address written during preload.
- DUMP_BASE, 128, first data-memory address read during dump.
- DUMP_LEN, 8, number of bytes streamed out after halt (1..2^ADDR_W).
- INIT_CYCLES, 2, cycles cpu_start is held high (>=1).
- CNT_W, 32, cycle counter width.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- go  in  1  sampled in IDLE only; starts a sequence.
- load_len  in  ADDR_W+1  bytes to preload, latched when go accepted; 0 = skip load.
- ld_data  in  8  preload byte.
- ld_valid  in  1  preload byte valid.
- ld_ready  out  1  sequencer accepts preload byte.
- dm_addr  out  ADDR_W  data-memory address.
- dm_wdata  out  8  data-memory write data.
- dm_we  out  1  data-memory write strobe.
- dm_re  out  1  data-memory read strobe.
- dm_rdata  in  8  data-memory read data, combinational from dm_addr.
- cpu_start  out  1  to core start/Init.
- cpu_halt  in  1  from core haltProgram.
- res_data  out  8  result byte.
- res_valid  out  1  result byte valid.
- res_ready  in  1  consumer accepts result byte.
- res_last  out  1  marks final result byte.
- cycle_count  out  CNT_W  core cycles from start release to halt.
- busy  out  1  high in any state except IDLE/DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (RST_N low, async): state IDLE; ld_ready, dm_we, dm_re, cpu_start, res_valid, res_last, busy, done = 0; res_data, dm_addr, dm_wdata, cycle_count = 0. Reset mid-sequence aborts immediately; no partial-state retention.
- States: IDLE, LOAD, INIT, RUN, DUMP, DONE.
- IDLE: go=1 → latch load_len. Next state is LOAD if load_len != 0, else INIT. Clear cycle_count.
- LOAD: ld_ready=1. Each cycle with ld_valid && ld_ready drives, combinationally that cycle, dm_we=1, dm_addr = LOAD_BASE + idx, dm_wdata = ld_data; then idx increments.
  - Address wraps modulo 2^ADDR_W.
  - After the load_len-th transfer, go to INIT. ld_ready is 0 the following cycle.
  - ld_valid low stalls with no write.
- INIT: cpu_start=1 for exactly INIT_CYCLES cycles, then RUN. dm_we/dm_re=0.
- RUN: cpu_start=0; cycle_count += 1 each cycle while cpu_halt=0, saturating at all-ones.
  - First RUN cycle with cpu_halt=1 → DUMP; that cycle is not counted.
  - cpu_halt already high on the first RUN cycle → cycle_count=0.
- DUMP: dm_re=1, dm_addr = DUMP_BASE + k (wrapping), k = 0..DUMP_LEN-1.
  - res_valid=1 with res_data = dm_rdata registered: one-cycle latency from address to res_valid.
  - res_data/res_valid hold stable while res_ready=0.
  - k advances only on the res_valid && res_ready handshake.
  - res_last=1 with byte DUMP_LEN-1.
  - Handshake on the last byte → DONE.
- DONE: done=1, cycle_count held. go=1 → restart as from IDLE, same cycle semantics.
- go outside IDLE/DONE is ignored.
- Simultaneous ld_valid and the state change out of LOAD: no extra byte accepted.

Optional Feature:
- RUN_TIMEOUT_EN defined:
  - Adds parameter TIMEOUT_CYCLES (default 4096) and output timeout (1 bit, reset 0).
  - In RUN, cycle_count reaching TIMEOUT_CYCLES without halt sets timeout=1 and forces DUMP.
  - timeout clears on the next accepted go.
- Not defined: no timeout port; RUN waits indefinitely for cpu_halt.

Test Plan:
- load_len=3, bytes 0x11,0x22,0x33 with ld_valid gaps → dm_we pulses at addr 0,1,2 with those data only on handshake cycles; then cpu_start high exactly 2 cycles.
- cpu_halt raised 10 cycles after cpu_start falls → cycle_count=10, DUMP begins next cycle, done after 8 handshakes.
- Dump with res_ready toggling 1,0,0,1… and memory 128..135 = 0xA0..0xA7 → bytes out in order, stable while stalled, res_last only on 0xA7.
- load_len=0 with go → no dm_we, straight to INIT; go while RUN → ignored, no state change.
- RST_N low during LOAD after 2 bytes → all outputs 0 asynchronously; new go after release restarts at LOAD_BASE.
- RUN_TIMEOUT_EN with TIMEOUT_CYCLES=16, cpu_halt held 0 → timeout=1 and cycle_count=16, dump completes; next go clears timeout.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: upstream control stage for the 9-bit processor core.
// It preloads data memory, pulses the core's start/Init and counts run cycles until halt.
// It then streams a result window of data memory out over a valid/ready port.
// Optional feature macro: RUN_TIMEOUT_EN adds TIMEOUT_CYCLES and a 'timeout' output.
// That feature bounds the RUN phase and forces a dump if the core never halts.
module run_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int LOAD_BASE   = 0,
    parameter int DUMP_BASE   = 128,
    parameter int DUMP_LEN    = 8,
    parameter int INIT_CYCLES = 2,
    parameter int CNT_W       = 32
`ifdef RUN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              go,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [7:0]        dm_wdata,
    output logic              dm_we,
    output logic              dm_re,
    input  logic [7:0]        dm_rdata,
    output logic              cpu_start,
    input  logic              cpu_halt,
    output logic [7:0]        res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_last,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              busy,
    output logic              done
`ifdef RUN_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] LOAD_BASE_A = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] DUMP_BASE_A = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W:0]   LAST_K      = (ADDR_W+1)'(DUMP_LEN - 1);
    localparam logic [INIT_W-1:0] INIT_LAST   = INIT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
`ifdef RUN_TIMEOUT_EN
    localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_e;

    state_e             state_q,     state_d;
    logic [ADDR_W:0]    len_q,       len_d;
    logic [ADDR_W:0]    idx_q,       idx_d;
    logic [INIT_W-1:0]  init_q,      init_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [ADDR_W:0]    k_q,         k_d;
    logic [7:0]         res_data_q,  res_data_d;
    logic               res_valid_q, res_valid_d;
    logic               res_last_q,  res_last_d;
`ifdef RUN_TIMEOUT_EN
    logic               timeout_q,   timeout_d;
`endif

    // State and datapath registers; reset drops everything back to an idle, empty sequencer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            init_q      <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
`ifdef RUN_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            init_q      <= init_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
`ifdef RUN_TIMEOUT_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Next-state and datapath update: phase sequencing, load index, run counter, dump handshake.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        init_d      = init_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
`ifdef RUN_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    len_d  = load_len;
                    idx_d  = '0;
                    init_d = '0;
                    cnt_d  = '0;
                    k_d    = '0;
`ifdef RUN_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d = (load_len != '0) ? S_LOAD : S_INIT;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    idx_d = idx_q + 1'b1;
                    if ((idx_q + 1'b1) == len_q) begin
                        state_d = S_INIT;
                    end
                end
            end
            S_INIT: begin
                if (init_q == INIT_LAST) begin
                    state_d = S_RUN;
                end else begin
                    init_d = init_q + 1'b1;
                end
            end
            S_RUN: begin
                if (cpu_halt) begin
                    state_d = S_DUMP;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`ifdef RUN_TIMEOUT_EN
                    if ((cnt_q + 1'b1) == TIMEOUT_VAL) begin
                        timeout_d = 1'b1;
                        state_d   = S_DUMP;
                    end
`endif
                end
            end
            S_DUMP: begin
                if (res_valid_q) begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        res_last_d  = 1'b0;
                        if (res_last_q) begin
                            state_d = S_DONE;
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end
                end else begin
                    res_valid_d = 1'b1;
                    res_data_d  = dm_rdata;
                    res_last_d  = (k_q == LAST_K);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the current phase; load-side strobes follow ld_valid in the same cycle.
    always_comb begin
        ld_ready  = 1'b0;
        dm_we     = 1'b0;
        dm_re     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        cpu_start = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                dm_we    = ld_valid;
                if (ld_valid) begin
                    dm_addr  = LOAD_BASE_A + idx_q[ADDR_W-1:0];
                    dm_wdata = ld_data;
                end
            end
            S_INIT: begin
                cpu_start = 1'b1;
            end
            S_DUMP: begin
                dm_re   = 1'b1;
                dm_addr = DUMP_BASE_A + k_q[ADDR_W-1:0];
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign res_data    = res_data_q;
    assign res_valid   = res_valid_q;
    assign res_last    = res_last_q;
    assign cycle_count = cnt_q;
`ifdef RUN_TIMEOUT_EN
    assign timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Testbench for run_sequencer: directed steps with randomized data, gaps, halt delays and back-pressure.
// Expected values come from a behavioural model of memory contents, load order and run length.
// When RUN_TIMEOUT_EN is defined the timeout path is exercised with TIMEOUT_CYCLES = 16.
module tb_run_sequencer;

    localparam int ADDR_W      = 8;
    localparam int LOAD_BASE   = 0;
    localparam int DUMP_BASE   = 128;
    localparam int DUMP_LEN    = 8;
    localparam int INIT_CYCLES = 2;
    localparam int CNT_W       = 32;
    localparam int MEM_SIZE    = 1 << ADDR_W;
`ifdef RUN_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 16;
`endif

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              go;
    logic [ADDR_W:0]   load_len;
    logic [7:0]        ld_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] dm_addr;
    logic [7:0]        dm_wdata;
    logic              dm_we;
    logic              dm_re;
    logic [7:0]        dm_rdata;
    logic              cpu_start;
    logic              cpu_halt;
    logic [7:0]        res_data;
    logic              res_valid;
    logic              res_ready;
    logic              res_last;
    logic [CNT_W-1:0]  cycle_count;
    logic              busy;
    logic              done;
`ifdef RUN_TIMEOUT_EN
    logic              timeout;
`endif

    int errors = 0;
    int checks = 0;

    // Environment data memory (written by the DUT or poked by the bench) and the model's view of it.
    logic [7:0]        envMem [0:MEM_SIZE-1];
    logic [7:0]        refMem [0:MEM_SIZE-1];
    logic              pokeEn;
    logic [ADDR_W-1:0] pokeAddr;
    logic [7:0]        pokeData;
    logic [7:0]        loadBytes [$];

    run_sequencer #(
        .ADDR_W      (ADDR_W),
        .LOAD_BASE   (LOAD_BASE),
        .DUMP_BASE   (DUMP_BASE),
        .DUMP_LEN    (DUMP_LEN),
        .INIT_CYCLES (INIT_CYCLES),
        .CNT_W       (CNT_W)
`ifdef RUN_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .go          (go),
        .load_len    (load_len),
        .ld_data     (ld_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_we       (dm_we),
        .dm_re       (dm_re),
        .dm_rdata    (dm_rdata),
        .cpu_start   (cpu_start),
        .cpu_halt    (cpu_halt),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_last    (res_last),
        .cycle_count (cycle_count),
        .busy        (busy),
        .done        (done)
`ifdef RUN_TIMEOUT_EN
        ,
        .timeout     (timeout)
`endif
    );

    // Free-running clock, period 10.
    always #5 CLK = ~CLK;

    // Environment memory: synchronous write from the DUT, or a bench poke when the DUT is not writing.
    always @(posedge CLK) begin
        if (dm_we) begin
            envMem[dm_addr] <= dm_wdata;
        end else if (pokeEn) begin
            envMem[pokeAddr] <= pokeData;
        end
    end

    assign dm_rdata = envMem[dm_addr];

    // Global safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstLdReady", ld_ready, 0);
        checkOutput("rstWe", dm_we, 0);
        checkOutput("rstRe", dm_re, 0);
        checkOutput("rstStart", cpu_start, 0);
        checkOutput("rstResValid", res_valid, 0);
        checkOutput("rstResLast", res_last, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstResData", res_data, 0);
        checkOutput("rstAddr", dm_addr, 0);
        checkOutput("rstWdata", dm_wdata, 0);
        checkOutput("rstCount", cycle_count, 0);
`ifdef RUN_TIMEOUT_EN
        checkOutput("rstTimeout", timeout, 0);
`endif
    endtask

    task automatic pokeDumpWindow(input bit fixedPattern);
        int a;
        logic [7:0] v;
        for (int i = 0; i < DUMP_LEN; i++) begin
            a = (DUMP_BASE + i) % MEM_SIZE;
            v = fixedPattern ? 8'(8'hA0 + i) : 8'($urandom);
            pokeEn   = 1'b1;
            pokeAddr = ADDR_W'(a);
            pokeData = v;
            refMem[a] = v;
            nextCycle();
        end
        pokeEn = 1'b0;
    endtask

    // One full sequence from go to done. readyMode: 0 = 1,0,0 repeating, 1 = random, 2 = always ready.
    task automatic applyStimulus(input int len, input int gapPct, input int haltDelay,
                                 input int readyMode, input bit goInRun, input bit expectTimeout);
        int idx;
        int guard;
        int k;
        int expCount;
        bit v;
        bit rdy;
        bit hs;
        bit prevStall;

        expCount = haltDelay;
`ifdef RUN_TIMEOUT_EN
        if (expectTimeout) expCount = TIMEOUT_CYCLES;
`endif

        go       = 1'b1;
        load_len = (ADDR_W+1)'(len);
        nextCycle();
        go       = 1'b0;

        idx   = 0;
        guard = 0;
        while (idx < len && guard < 1000) begin
            v        = ($urandom_range(99) >= gapPct);
            ld_valid = v;
            ld_data  = v ? loadBytes[idx] : 8'($urandom);
            @(negedge CLK);
            checkOutput("ldReady", ld_ready, 1);
            checkOutput("ldWe", dm_we, v);
            if (v) begin
                checkOutput("ldAddr", dm_addr, (LOAD_BASE + idx) % MEM_SIZE);
                checkOutput("ldData", dm_wdata, loadBytes[idx]);
                refMem[(LOAD_BASE + idx) % MEM_SIZE] = loadBytes[idx];
            end
            nextCycle();
            if (v) idx++;
            guard++;
        end
        if (idx < len) checkOutput("loadBound", idx, len);

        // Keep offering a byte across the exit from LOAD; it must not be taken.
        ld_valid = 1'b1;
        ld_data  = 8'($urandom);
        for (int i = 0; i < INIT_CYCLES; i++) begin
            @(negedge CLK);
            checkOutput("initStart", cpu_start, 1);
            checkOutput("initNoLd", ld_ready, 0);
            checkOutput("initNoWe", dm_we, 0);
`ifdef RUN_TIMEOUT_EN
            checkOutput("timeoutClr", timeout, 0);
`endif
            nextCycle();
            ld_valid = 1'b0;
        end

        cpu_halt = 1'b0;
        for (int r = 0; r < haltDelay; r++) begin
            if (goInRun && r == 1) begin
                go       = 1'b1;
                load_len = (ADDR_W+1)'(5);
            end
            @(negedge CLK);
            checkOutput("runStart", cpu_start, 0);
            checkOutput("runNoLd", ld_ready, 0);
            checkOutput("runBusy", busy, 1);
            if (r == 0) checkOutput("runCntClr", cycle_count, 0);
            nextCycle();
            go = 1'b0;
        end

        if (!expectTimeout) begin
            cpu_halt = 1'b1;
            @(negedge CLK);
            checkOutput("haltCount", cycle_count, haltDelay);
            checkOutput("haltNoStart", cpu_start, 0);
            nextCycle();
            cpu_halt = 1'b0;
        end

        k         = 0;
        guard     = 0;
        prevStall = 1'b0;
        while (k < DUMP_LEN && guard < 200) begin
            case (readyMode)
                0:       rdy = ((guard % 3) == 0);
                1:       rdy = 1'($urandom_range(1));
                default: rdy = 1'b1;
            endcase
            res_ready = rdy;
            @(negedge CLK);
            checkOutput("dumpRe", dm_re, 1);
            checkOutput("dumpAddr", dm_addr, (DUMP_BASE + k) % MEM_SIZE);
            checkOutput("dumpBusy", busy, 1);
            if (guard == 0) checkOutput("dumpLatency", res_valid, 0);
            if (prevStall) checkOutput("dumpHold", res_valid, 1);
            if (res_valid === 1'b1) begin
                checkOutput("dumpData", res_data, refMem[(DUMP_BASE + k) % MEM_SIZE]);
                checkOutput("dumpLast", res_last, (k == DUMP_LEN - 1));
            end
            prevStall = (res_valid === 1'b1) && !rdy;
            hs        = (res_valid === 1'b1) && rdy;
            nextCycle();
            if (hs) k++;
            guard++;
        end
        checkOutput("dumpBound", k, DUMP_LEN);
        res_ready = 1'b0;

        @(negedge CLK);
        checkOutput("doneFlag", done, 1);
        checkOutput("doneBusy", busy, 0);
        checkOutput("doneValid", res_valid, 0);
        checkOutput("doneCount", cycle_count, expCount);
`ifdef RUN_TIMEOUT_EN
        checkOutput("doneTimeout", timeout, expectTimeout);
`endif
        nextCycle();
    endtask

    initial begin
        int nLen;

        RST_N     = 1'b0;
        go        = 1'b0;
        load_len  = '0;
        ld_data   = '0;
        ld_valid  = 1'b0;
        cpu_halt  = 1'b0;
        res_ready = 1'b0;
        pokeEn    = 1'b0;
        pokeAddr  = '0;
        pokeData  = '0;

        // Step 1: reset state.
        #3;
        checkResetOutputs();
        #9;
        RST_N = 1'b1;
        nextCycle();

        // Step 2: three-byte load with gaps, halt after 10 run cycles, 1,0,0 back-pressure, go ignored in RUN.
        pokeDumpWindow(1'b1);
        loadBytes = '{8'h11, 8'h22, 8'h33};
        applyStimulus(3, 40, 10, 0, 1'b1, 1'b0);

        // Step 3: halt already high on the first run cycle, restarted from DONE.
        loadBytes = '{8'h44};
        applyStimulus(1, 0, 0, 2, 1'b0, 1'b0);

        // Step 4: randomized sequences.
        for (int n = 0; n < 4; n++) begin
            nLen = $urandom_range(1, 10);
            loadBytes.delete();
            for (int i = 0; i < nLen; i++) loadBytes.push_back(8'($urandom));
            pokeDumpWindow(1'b0);
            applyStimulus(nLen, 30, $urandom_range(0, 14), 1, 1'b0, 1'b0);
        end

        // Step 5: empty load goes straight to INIT.
        loadBytes.delete();
        applyStimulus(0, 0, 4, 2, 1'b0, 1'b0);

        // Step 6: asynchronous reset in the middle of a load, then a fresh load from the base address.
        go       = 1'b1;
        load_len = (ADDR_W+1)'(4);
        nextCycle();
        go       = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 8'h5A;
        nextCycle();
        ld_data  = 8'h6B;
        nextCycle();
        ld_data  = 8'h7C;
        #2;
        checkOutput("preResetWe", dm_we, 1);
        RST_N = 1'b0;
        #1;
        checkResetOutputs();
        ld_valid = 1'b0;
        #2;
        RST_N = 1'b1;
        nextCycle();
        loadBytes = '{8'($urandom), 8'($urandom)};
        pokeDumpWindow(1'b0);
        applyStimulus(2, 0, 5, 1, 1'b0, 1'b0);

`ifdef RUN_TIMEOUT_EN
        // Step 7: core never halts; timeout forces the dump, the next go clears the flag.
        loadBytes = '{8'h99};
        pokeDumpWindow(1'b0);
        applyStimulus(1, 0, TIMEOUT_CYCLES, 1, 1'b0, 1'b1);
        loadBytes = '{8'h9A};
        applyStimulus(1, 0, 3, 2, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
